// File: rtl/super_pkg.sv
// Shared decode types: the ir_dec_t record handed from fetch to the decoders,
// plus the CHERI opcode/funct7 constants used by pre-decode.
package super_pkg;

  localparam logic [6:0] OPCODE_CHERI = 7'h5b;
  localparam logic [6:0] CINCADDR_F7  = 7'h11;
  localparam logic [6:0] CSUB_F7      = 7'h14;

  typedef struct packed {
    logic cincaddr;
    logic csub;
    logic cincaddrimm;
    logic cgetaddr;
    logic csetaddr;
  } cheri_op_t;

  typedef struct packed {
    logic [31:0] insn;
    logic        is_comp;
    cheri_op_t   cheri_op;
  } ir_dec_t;

endpackage

// File: rtl/ir_predecode.sv
// Purely combinational pre-decode of an expanded 32-bit instruction into an
// ir_dec_t record; shared by any fetch path that feeds the decoders.
module ir_predecode
  import super_pkg::*;
#(
  parameter bit CHERIoTEn = 1'b1
) (
  input  logic [31:0] insn_i,
  input  logic        is_comp_i,
  input  logic        cheri_pmode_i,
  output ir_dec_t     ir_o
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       cheri_en;

  assign opcode   = insn_i[6:0];
  assign funct3   = insn_i[14:12];
  assign funct7   = insn_i[31:25];
  assign cheri_en = CHERIoTEn && cheri_pmode_i && (opcode == OPCODE_CHERI);

  // Only the three ops with a dedicated ALU fast path are flagged here;
  // the remaining cheri_op fields stay zero.
  always_comb begin
    ir_o                      = '0;
    ir_o.insn                 = insn_i;
    ir_o.is_comp              = is_comp_i;
    ir_o.cheri_op.cincaddr    = cheri_en && (funct3 == 3'd0) && (funct7 == CINCADDR_F7);
    ir_o.cheri_op.csub        = cheri_en && (funct3 == 3'd0) && (funct7 == CSUB_F7);
    ir_o.cheri_op.cincaddrimm = cheri_en && (funct3 == 3'd1);
  end

endmodule

// File: rtl/ir_dec_queue.sv
// FIFO of pre-decoded ir_dec_t records between fetch and decode.
// Define IR_DEC_QUEUE_BYPASS_EN for a same-cycle path through an empty queue.
module ir_dec_queue
  import super_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter bit CHERIoTEn = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     cheri_pmode_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [31:0]              in_insn_i,
  input  logic                     in_is_comp_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output ir_dec_t                  out_ir_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg, count_next;
  ir_dec_t       mem [DEPTH];
  ir_dec_t       pre_ir;
  logic          empty, bypass, push, pop;

  ir_predecode #(
    .CHERIoTEn(CHERIoTEn)
  ) u_predecode (
    .insn_i       (in_insn_i),
    .is_comp_i    (in_is_comp_i),
    .cheri_pmode_i(cheri_pmode_i),
    .ir_o         (pre_ir)
  );

  assign empty      = (count_reg == '0);
  assign in_ready_o = (count_reg < CW'(DEPTH));

`ifdef IR_DEC_QUEUE_BYPASS_EN
  assign bypass = empty && in_valid_i && !flush_i;
`else
  assign bypass = 1'b0;
`endif

  assign out_valid_o = !empty || bypass;
  assign count_o     = count_reg;

  // A bypassed word consumed in the same cycle never touches storage.
  assign push = in_valid_i && in_ready_o && !(bypass && out_ready_i) && !flush_i;
  assign pop  = !empty && out_ready_i && !flush_i;

  always_comb begin
    out_ir_o = '0;
    if (!empty) begin
      out_ir_o = mem[rd_ptr_reg];
    end else if (bypass) begin
      out_ir_o = pre_ir;
    end
  end

  always_comb begin
    count_next = count_reg;
    if (push && !pop) begin
      count_next = count_reg + 1'b1;
    end else if (pop && !push) begin
      count_next = count_reg - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
    end
  end

  // Storage carries no reset; stale entries are masked by the count.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk_i) begin
      if (push && (wr_ptr_reg == AW'(gi))) begin
        mem[gi] <= pre_ir;
      end
    end
  end

endmodule

// File: tb/tb_ir_dec_queue.sv
// Self-checking bench for ir_dec_queue: table-driven pre-decode vectors,
// directed corner sequences and a randomized run against a queue model.
module tb_ir_dec_queue;
  import super_pkg::*;

  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        flush_i = 1'b0;
  logic        cheri_pmode_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [31:0] in_insn_i = '0;
  logic        in_is_comp_i = 1'b0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  ir_dec_t     out_ir_o;
  logic [2:0]  count_o;

  ir_dec_queue #(.DEPTH(DEPTH), .CHERIoTEn(1'b1)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .flush_i      (flush_i),
    .cheri_pmode_i(cheri_pmode_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .in_insn_i    (in_insn_i),
    .in_is_comp_i (in_is_comp_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_ir_o     (out_ir_o),
    .count_o      (count_o)
  );

  always #5 clk_i = ~clk_i;

  int      errors = 0;
  int      checks = 0;
  ir_dec_t model_q[$];
  ir_dec_t last_pop;
  logic    seen_valid;

  typedef struct {
    logic [31:0] insn;
    logic        comp;
    logic        pmode;
    logic [2:0]  flags;  // {cincaddr, csub, cincaddrimm}
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference pre-decode from the instruction field rules, in plain arithmetic.
  function automatic ir_dec_t ref_pre(logic [31:0] w, logic c, logic pm);
    ir_dec_t r;
    int unsigned op, f3, f7;
    r = '0;
    r.insn = w;
    r.is_comp = c;
    op = w % 128;
    f3 = (w / 4096) % 8;
    f7 = w / (1 << 25);
    if (pm && op == 91) begin
      r.cheri_op.cincaddr    = (f3 == 0) && (f7 == 17);
      r.cheri_op.csub        = (f3 == 0) && (f7 == 20);
      r.cheri_op.cincaddrimm = (f3 == 1);
    end
    return r;
  endfunction

  // One clock: drive at negedge, check against the model, advance the model at posedge.
  task automatic cycle(input logic v, input logic [31:0] w, input logic c,
                       input logic pm, input logic rdy, input logic fl);
    logic    byp, e_valid, e_ready, do_pop, do_push;
    ir_dec_t e_ir;
    int      sz;
    in_valid_i = v; in_insn_i = w; in_is_comp_i = c;
    cheri_pmode_i = pm; out_ready_i = rdy; flush_i = fl;
    #1;
    sz = model_q.size();
    byp = 1'b0;
`ifdef IR_DEC_QUEUE_BYPASS_EN
    byp = (sz == 0) && v && !fl;
`endif
    e_valid = (sz != 0) || byp;
    e_ready = (sz < DEPTH);
    e_ir = (sz != 0) ? model_q[0] : (byp ? ref_pre(w, c, pm) : '0);
    chk("count", 64'(count_o), 64'(sz));
    chk("out_valid", 64'(out_valid_o), 64'(e_valid));
    chk("in_ready", 64'(in_ready_o), 64'(e_ready));
    chk("out_ir", 64'(out_ir_o), 64'(e_ir));
    seen_valid = out_valid_o;
    do_pop = e_valid && rdy && !fl;
    do_push = v && e_ready && !(byp && rdy) && !fl;
    if (do_pop) last_pop = out_ir_o;
    $display("t=%0t v=%0b insn=%08h rdy=%0b fl=%0b count=%0d out_valid=%0b out_insn=%08h",
             $time, v, w, rdy, fl, count_o, out_valid_o, out_ir_o.insn);
    @(posedge clk_i);
    if (fl) model_q.delete();
    else begin
      if (do_pop && sz != 0) void'(model_q.pop_front());
      if (do_push) model_q.push_back(ref_pre(w, c, pm));
    end
    @(negedge clk_i);
  endtask

  task automatic go_idle();
    in_valid_i = 1'b0; out_ready_i = 1'b0; flush_i = 1'b0;
    #1;
  endtask

  initial begin
    vecs[0] = '{32'h222080DB, 1'b0, 1'b1, 3'b100};
    vecs[1] = '{32'h282080DB, 1'b1, 1'b1, 3'b010};
    vecs[2] = '{32'h004090DB, 1'b0, 1'b1, 3'b001};
    vecs[3] = '{32'h222080DB, 1'b1, 1'b0, 3'b000};
    vecs[4] = '{32'h282080DB, 1'b0, 1'b0, 3'b000};
    vecs[5] = '{32'h004090DB, 1'b1, 1'b0, 3'b000};

    // Reset state
    #2;
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_valid", 64'(out_valid_o), 64'd0);
    chk("rst_ready", 64'(in_ready_o), 64'd1);
    chk("rst_ir", 64'(out_ir_o), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Single add, one-cycle latency
    cycle(1, 32'h002080B3, 0, 0, 0, 0);
    go_idle();
    chk("add_valid", 64'(out_valid_o), 64'd1);
    chk("add_count", 64'(count_o), 64'd1);
    chk("add_insn", 64'(out_ir_o.insn), 64'h002080B3);
    chk("add_flags", 64'(out_ir_o.cheri_op), 64'd0);
    cycle(0, 0, 0, 0, 1, 0);

    // Table-driven pre-decode: push three, then pop three in order
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 3; i++)
        cycle(1, vecs[b*3+i].insn, vecs[b*3+i].comp, vecs[b*3+i].pmode, 0, 0);
      for (int i = 0; i < 3; i++) begin
        ir_dec_t e;
        e = '0;
        e.insn = vecs[b*3+i].insn;
        e.is_comp = vecs[b*3+i].comp;
        e.cheri_op.cincaddr = vecs[b*3+i].flags[2];
        e.cheri_op.csub = vecs[b*3+i].flags[1];
        e.cheri_op.cincaddrimm = vecs[b*3+i].flags[0];
        // Flip pmode on the pop side: flags must reflect push-time pmode
        cycle(0, 0, 0, !vecs[b*3+i].pmode, 1, 0);
        chk("vec_pop", 64'(last_pop), 64'(e));
      end
    end

    // Fill, then push+pop while full, then run across the pointer wrap
    for (int i = 0; i < DEPTH; i++) cycle(1, 32'h1000 + i, 0, 0, 0, 0);
    go_idle();
    chk("full_ready", 64'(in_ready_o), 64'd0);
    cycle(1, 32'h2000, 0, 0, 1, 0);
    chk("full_pop_head", 64'(last_pop.insn), 64'h1000);
    go_idle();
    chk("full_pp_count", 64'(count_o), 64'd3);
    for (int i = 0; i < 10; i++) cycle(1, 32'h3000 + i, 0, 0, 1, 0);

    // Flush with count 3 and a simultaneous push
    go_idle();
    chk("pre_flush_count", 64'(count_o), 64'd3);
    cycle(1, 32'hDEADBEEF, 0, 0, 1, 1);
    go_idle();
    chk("flush_count", 64'(count_o), 64'd0);
    chk("flush_valid", 64'(out_valid_o), 64'd0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1, 0);

    // Empty queue, push with out_ready high
    cycle(1, 32'h00000013, 0, 0, 1, 0);
`ifdef IR_DEC_QUEUE_BYPASS_EN
    chk("byp_same_valid", 64'(seen_valid), 64'd1);
    go_idle();
    chk("byp_count", 64'(count_o), 64'd0);
`else
    chk("nobyp_same_valid", 64'(seen_valid), 64'd0);
    go_idle();
    chk("nobyp_next_valid", 64'(out_valid_o), 64'd1);
    chk("nobyp_count", 64'(count_o), 64'd1);
    cycle(0, 0, 0, 0, 1, 0);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      logic [31:0] w;
      w = $urandom;
      if ($urandom_range(1, 0) == 1) begin
        w[6:0] = 7'h5b;
        w[14:12] = 3'($urandom_range(1, 0));
        w[31:25] = ($urandom_range(1, 0) == 1) ? 7'h11 : 7'h14;
      end
      cycle(1'($urandom_range(1, 0)), w, 1'($urandom_range(1, 0)),
            1'($urandom_range(1, 0)), ($urandom_range(3, 0) != 0),
            ($urandom_range(19, 0) == 0));
    end

    // Async reset mid-cycle with entries held
    for (int i = 0; i < 3; i++) cycle(1, 32'h4000 + i, 0, 0, 0, 0);
    go_idle();
    #1 rst_ni = 1'b0;
    #1;
    chk("arst_count", 64'(count_o), 64'd0);
    chk("arst_ready", 64'(in_ready_o), 64'd1);
    chk("arst_valid", 64'(out_valid_o), 64'd0);
    model_q.delete();
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int i = 0; i < 4; i++) cycle(1, 32'h5000 + i, 1, 1, 1, 0);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
